ex_stage: RTL and testbench

//  Execute stage of the 5-stage 32-bit MIPS-style pipeline, placed between the ID and MEM stages.
//  - Selects the ALU operands and performs the ALU operation.
//  - Computes the branch target and picks the destination register.
//  - Registers the results together with the forwarded MEM/WB control fields.
//  - Output bank is the EX/MEM pipeline register. Latency is 1 clock.

---
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS-style pipeline: operand select, ALU, branch target,
// destination select, all captured in the EX/MEM pipeline register (latency 1).
module ex_stage #(
    parameter int NB_data = 32,
    parameter int NB_addr = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_data-1:0] in_branch,
    input  logic [7:0]         in_ex,
    input  logic [2:0]         in_mem,
    input  logic [1:0]         in_wb,
    input  logic [NB_data-1:0] in_reg1,
    input  logic [NB_data-1:0] in_reg2,
    input  logic [NB_data-1:0] in_inmediato,
    input  logic [NB_addr-1:0] in_shamt,
    input  logic [NB_addr-1:0] in_rt,
    input  logic [NB_addr-1:0] in_rd,
    input  logic [NB_data-1:0] in_jump_reg,
    output logic [NB_data-1:0] out_branch,
    output logic [NB_data-1:0] out_alu,
    output logic [NB_addr-1:0] out_reg_dest,
    output logic [NB_data-1:0] out_w_data,
    output logic               out_zero,
    output logic               out_sign,
    output logic [2:0]         out_mem,
    output logic [1:0]         out_wb,
    output logic [NB_data-1:0] out_jump_reg
);

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_SLLV = 4'd3;
    localparam logic [3:0] OP_SRLV = 4'd4;
    localparam logic [3:0] OP_SRAV = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_LUI  = 4'd13;

    logic [NB_data-1:0] op_b_s;
    logic [NB_addr-1:0] var_sh_s;
    logic [NB_data-1:0] alu_d,      alu_q;
    logic [NB_data-1:0] branch_d,   branch_q;
    logic [NB_addr-1:0] reg_dest_d, reg_dest_q;
    logic               zero_d,     zero_q;
    logic               sign_d,     sign_q;
    logic [NB_data-1:0] w_data_q;
    logic [2:0]         mem_q;
    logic [1:0]         wb_q;
    logic [NB_data-1:0] jump_reg_q;

    // Jump qualifiers are consumed by IF; they are deliberately ignored here.
    logic unused_ex_s;
    assign unused_ex_s = ^in_ex[1:0];

    // ALU, branch target and destination select ahead of the pipeline register
    always_comb begin
        op_b_s     = in_ex[6] ? in_inmediato : in_reg2;
        var_sh_s   = in_reg1[NB_addr-1:0];
        alu_d      = {NB_data{1'b0}};
        case (in_ex[5:2])
            OP_SLL:  alu_d = op_b_s << in_shamt;
            OP_SRL:  alu_d = op_b_s >> in_shamt;
            OP_SRA:  alu_d = $unsigned($signed(op_b_s) >>> in_shamt);
            OP_SLLV: alu_d = op_b_s << var_sh_s;
            OP_SRLV: alu_d = op_b_s >> var_sh_s;
            OP_SRAV: alu_d = $unsigned($signed(op_b_s) >>> var_sh_s);
            OP_ADD:  alu_d = in_reg1 + op_b_s;
            OP_SUB:  alu_d = in_reg1 - op_b_s;
            OP_AND:  alu_d = in_reg1 & op_b_s;
            OP_OR:   alu_d = in_reg1 | op_b_s;
            OP_XOR:  alu_d = in_reg1 ^ op_b_s;
            OP_NOR:  alu_d = ~(in_reg1 | op_b_s);
            OP_SLT:  alu_d = ($signed(in_reg1) < $signed(op_b_s)) ?
                             {{(NB_data-1){1'b0}}, 1'b1} : {NB_data{1'b0}};
            OP_LUI:  alu_d = op_b_s << 5'd16;
            default: alu_d = {NB_data{1'b0}};
        endcase
        zero_d     = (alu_d == {NB_data{1'b0}});
        sign_d     = alu_d[NB_data-1];
        branch_d   = in_branch + (in_inmediato << 2);
        reg_dest_d = in_ex[7] ? in_rd : in_rt;
    end

    // EX/MEM pipeline register, loads every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q      <= {NB_data{1'b0}};
            branch_q   <= {NB_data{1'b0}};
            reg_dest_q <= {NB_addr{1'b0}};
            w_data_q   <= {NB_data{1'b0}};
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
            mem_q      <= 3'd0;
            wb_q       <= 2'd0;
            jump_reg_q <= {NB_data{1'b0}};
        end else begin
            alu_q      <= alu_d;
            branch_q   <= branch_d;
            reg_dest_q <= reg_dest_d;
            w_data_q   <= in_reg2;
            zero_q     <= zero_d;
            sign_q     <= sign_d;
            mem_q      <= in_mem;
            wb_q       <= in_wb;
            jump_reg_q <= in_jump_reg;
        end
    end

    assign out_alu      = alu_q;
    assign out_branch   = branch_q;
    assign out_reg_dest = reg_dest_q;
    assign out_w_data   = w_data_q;
    assign out_zero     = zero_q;
    assign out_sign     = sign_q;
    assign out_mem      = mem_q;
    assign out_wb       = wb_q;
    assign out_jump_reg = jump_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Table-driven bench for ex_stage: expected results are queued when inputs are driven
// and popped when the registered outputs appear.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_branch, in_reg1, in_reg2, in_inmediato, in_jump_reg;
    logic [7:0]  in_ex;
    logic [2:0]  in_mem;
    logic [1:0]  in_wb;
    logic [4:0]  in_shamt, in_rt, in_rd;
    logic [31:0] out_branch, out_alu, out_w_data, out_jump_reg;
    logic [4:0]  out_reg_dest;
    logic        out_zero, out_sign;
    logic [2:0]  out_mem;
    logic [1:0]  out_wb;

    ex_stage #(.NB_data(32), .NB_addr(5)) dut (
        .clk(clk), .reset(reset), .in_branch(in_branch), .in_ex(in_ex), .in_mem(in_mem),
        .in_wb(in_wb), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_inmediato(in_inmediato),
        .in_shamt(in_shamt), .in_rt(in_rt), .in_rd(in_rd), .in_jump_reg(in_jump_reg),
        .out_branch(out_branch), .out_alu(out_alu), .out_reg_dest(out_reg_dest),
        .out_w_data(out_w_data), .out_zero(out_zero), .out_sign(out_sign),
        .out_mem(out_mem), .out_wb(out_wb), .out_jump_reg(out_jump_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] br;  logic [31:0] alu; logic [4:0] rd; logic [31:0] w;
        logic z; logic s; logic [2:0] mem; logic [1:0] wb; logic [31:0] jr;
    } exp_t;

    typedef struct {
        logic [7:0] ex; logic [2:0] mem; logic [1:0] wb; logic [31:0] br;
        logic [31:0] r1; logic [31:0] r2; logic [31:0] imm; logic [4:0] sh;
        logic [4:0] rt; logic [4:0] rd; logic [31:0] jr;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[19];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [7:0] mk_ex(input logic rdst, input logic src,
                                         input logic [3:0] op, input logic [1:0] jj);
        return {rdst, src, op, jj};
    endfunction

    task automatic drive(input vec_t v);
        in_ex = v.ex; in_mem = v.mem; in_wb = v.wb; in_branch = v.br;
        in_reg1 = v.r1; in_reg2 = v.r2; in_inmediato = v.imm; in_shamt = v.sh;
        in_rt = v.rt; in_rd = v.rd; in_jump_reg = v.jr;
    endtask

    task automatic chk(input string name, input string fld, input logic [31:0] act,
                       input logic [31:0] want);
        if (act !== want) begin
            n_err++;
            $display("FAIL %s %s: got %h, expected %h", name, fld, act, want);
        end
    endtask

    task automatic compare(input string name);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, "branch",   out_branch,           e.br);
            chk(name, "alu",      out_alu,              e.alu);
            chk(name, "reg_dest", {27'd0, out_reg_dest}, {27'd0, e.rd});
            chk(name, "w_data",   out_w_data,           e.w);
            chk(name, "zero",     {31'd0, out_zero},    {31'd0, e.z});
            chk(name, "sign",     {31'd0, out_sign},    {31'd0, e.s});
            chk(name, "mem",      {29'd0, out_mem},     {29'd0, e.mem});
            chk(name, "wb",       {30'd0, out_wb},      {30'd0, e.wb});
            chk(name, "jump_reg", out_jump_reg,         e.jr);
        end
    endtask

    initial begin
        exp_t zero_e;
        zero_e = '{32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0};

        //          ex                           mem   wb    br            r1            r2            imm           sh     rt     rd     jr
        vecs[0]  = '{mk_ex(1'b1,1'b1,4'd6,2'b11), 3'd5, 2'd2, 32'h00000100, 32'h00000005, 32'h00000077, 32'hFFFFFFFE, 5'd0,  5'd2,  5'd1,  32'h00001234,
                     '{32'h000000F8, 32'h00000003, 5'd1,  32'h00000077, 1'b0, 1'b0, 3'd5, 2'd2, 32'h00001234}};
        vecs[1]  = '{mk_ex(1'b0,1'b0,4'd7,2'b00), 3'd0, 2'd0, 32'h00000100, 32'h00000044, 32'h00000044, 32'hFFFFFFFF, 5'd0,  5'd2,  5'd1,  32'h00000000,
                     '{32'h000000FC, 32'h00000000, 5'd2,  32'h00000044, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[2]  = '{mk_ex(1'b1,1'b0,4'd12,2'b00),3'd3, 2'd1, 32'h00000200, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd0,  5'd3,  5'd4,  32'h0000ABCD,
                     '{32'h00000200, 32'h00000001, 5'd4,  32'h00000001, 1'b0, 1'b0, 3'd3, 2'd1, 32'h0000ABCD}};
        vecs[3]  = '{mk_ex(1'b0,1'b0,4'd2,2'b01), 3'd7, 2'd3, 32'h00000010, 32'h00000000, 32'h80000000, 32'h00000001, 5'd4,  5'd31, 5'd0,  32'hFFFFFFFF,
                     '{32'h00000014, 32'hF8000000, 5'd31, 32'h80000000, 1'b0, 1'b1, 3'd7, 2'd3, 32'hFFFFFFFF}};
        vecs[4]  = '{mk_ex(1'b1,1'b1,4'd13,2'b00),3'd1, 2'd0, 32'h00000000, 32'h00000000, 32'h0000DEAD, 32'h00000001, 5'd0,  5'd5,  5'd6,  32'h00000000,
                     '{32'h00000004, 32'h00010000, 5'd6,  32'h0000DEAD, 1'b0, 1'b0, 3'd1, 2'd0, 32'h00000000}};
        vecs[5]  = '{mk_ex(1'b0,1'b0,4'd0,2'b00), 3'd0, 2'd0, 32'h00000010, 32'h00000000, 32'h00000001, 32'h40000000, 5'd31, 5'd7,  5'd8,  32'h00000000,
                     '{32'h00000010, 32'h80000000, 5'd7,  32'h00000001, 1'b0, 1'b1, 3'd0, 2'd0, 32'h00000000}};
        vecs[6]  = '{mk_ex(1'b0,1'b0,4'd1,2'b00), 3'd0, 2'd0, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 5'd31, 5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[7]  = '{mk_ex(1'b0,1'b0,4'd3,2'b00), 3'd0, 2'd0, 32'h00000000, 32'h00000024, 32'h0000000F, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h000000F0, 5'd1,  32'h0000000F, 1'b0, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[8]  = '{mk_ex(1'b0,1'b0,4'd4,2'b00), 3'd0, 2'd0, 32'h00000000, 32'h00000020, 32'h12345678, 32'h00000000, 5'd7,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h12345678, 5'd1,  32'h12345678, 1'b0, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[9]  = '{mk_ex(1'b0,1'b0,4'd5,2'b00), 3'd0, 2'd0, 32'h00000000, 32'h00000001, 32'h80000001, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'hC0000000, 5'd1,  32'h80000001, 1'b0, 1'b1, 3'd0, 2'd0, 32'h00000000}};
        vecs[10] = '{mk_ex(1'b0,1'b0,4'd8,2'b00), 3'd0, 2'd0, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'hF000F000, 5'd1,  32'hFF00FF00, 1'b0, 1'b1, 3'd0, 2'd0, 32'h00000000}};
        vecs[11] = '{mk_ex(1'b0,1'b0,4'd9,2'b00), 3'd0, 2'd0, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'hFFF0FFF0, 5'd1,  32'hFF00FF00, 1'b0, 1'b1, 3'd0, 2'd0, 32'h00000000}};
        vecs[12] = '{mk_ex(1'b0,1'b0,4'd10,2'b00),3'd0, 2'd0, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h0FF00FF0, 5'd1,  32'hFF00FF00, 1'b0, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[13] = '{mk_ex(1'b0,1'b0,4'd11,2'b00),3'd0, 2'd0, 32'h00000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h000F000F, 5'd1,  32'hFF00FF00, 1'b0, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[14] = '{mk_ex(1'b0,1'b0,4'd6,2'b00), 3'd0, 2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h00000000, 5'd1,  32'h00000001, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[15] = '{mk_ex(1'b0,1'b0,4'd12,2'b00),3'd0, 2'd0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'd0,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h00000000, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[16] = '{mk_ex(1'b0,1'b0,4'd14,2'b00),3'd0, 2'd0, 32'h00000000, 32'h00000005, 32'h00000006, 32'h00000000, 5'd3,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h00000000, 5'd1,  32'h00000006, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[17] = '{mk_ex(1'b0,1'b0,4'd15,2'b00),3'd0, 2'd0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'd3,  5'd1,  5'd2,  32'h00000000,
                     '{32'h00000000, 32'h00000000, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000000}};
        vecs[18] = '{mk_ex(1'b0,1'b1,4'd7,2'b00), 3'd2, 2'd1, 32'h00000000, 32'h0000000A, 32'h00000003, 32'h00000004, 5'd0,  5'd9,  5'd2,  32'h00000000,
                     '{32'h00000010, 32'h00000006, 5'd9,  32'h00000003, 1'b0, 1'b0, 3'd2, 2'd1, 32'h00000000}};

        // Reset held with live inputs: outputs stay zero across edges.
        reset = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(zero_e);
        compare("reset_hold");

        // Release: nothing changes until the next rising edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.push_back(zero_e);
        compare("release_pre_edge");
        exp_q.push_back(vecs[0].e);
        @(posedge clk);
        #1;
        compare("release_post_edge");

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i));
        end

        // Async reset mid-cycle clears the pass-through fields immediately.
        @(negedge clk);
        drive(vecs[0]);
        exp_q.push_back(vecs[0].e);
        @(posedge clk);
        #1;
        compare("pre_async");
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(zero_e);
        compare("async_clear");
        @(negedge clk);
        reset = 1'b1;
        drive(vecs[3]);
        exp_q.push_back(vecs[3].e);
        @(posedge clk);
        #1;
        compare("post_async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
